// File: rtl/dma_fifo_drain.sv
// dma_fifo_drain: pops a two-word descriptor plus payload from a show-ahead FIFO and
// turns it into word writes with address increment, tail strobes and completion pulses.
module dma_fifo_drain #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    input  logic [31:0]      fifo_dout,
    output logic             fifo_rd_en,
    output logic             mem_wren,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic             mem_ready,
    output logic             busy,
    output logic             done_pulse,
    output logic             err_pulse,
    output logic [CNT_W-1:0] pkt_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData,
        StFlush
    } state_e;

    state_e           state_q, state_d;
    // One bit wider than 14 so LEN 65533..65535 (16384 words) does not alias to zero.
    logic [14:0]      words_left_q, words_left_d;
    logic [1:0]       len_lsb_q, len_lsb_d;
    logic [31:0]      next_addr_q, next_addr_d;
    logic             wren_q, wren_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             pop;
    logic             accept;
    logic [14:0]      desc_words;
    logic [3:0]       tail_strb;

    assign desc_words = {1'b0, fifo_dout[31:18]} + 15'(|fifo_dout[17:16]);
    assign accept     = wren_q & mem_ready;

    always_comb begin
        tail_strb = 4'hF;
        unique case (len_lsb_q)
            2'd1:    tail_strb = 4'h1;
            2'd2:    tail_strb = 4'h3;
            2'd3:    tail_strb = 4'h7;
            default: tail_strb = 4'hF;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        words_left_d = words_left_q;
        len_lsb_d    = len_lsb_q;
        next_addr_d  = next_addr_q;
        wren_d       = wren_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        pop          = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Hold off the next descriptor while a completion/error pulse is showing.
                pop = ~fifo_empty & ~done_q & ~err_q;
                if (pop) begin
                    words_left_d = desc_words;
                    len_lsb_d    = fifo_dout[17:16];
                    state_d      = StAddr;
                end
            end
            StAddr: begin
                pop = ~fifo_empty;
                if (pop) begin
                    next_addr_d = {fifo_dout[31:2], 2'b00};
                    if (words_left_q == '0) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                pop = ~fifo_empty & (words_left_q != '0) & (~wren_q | mem_ready);
                if (pop) begin
                    wren_d       = 1'b1;
                    addr_d       = next_addr_q;
                    next_addr_d  = next_addr_q + 32'd4;
                    wdata_d      = fifo_dout;
                    wstrb_d      = (words_left_q == 15'd1) ? tail_strb : 4'hF;
                    words_left_d = words_left_q - 15'd1;
                    if (words_left_q == 15'd1) begin
                        state_d = StFlush;
                    end
                end else if (accept) begin
                    wren_d = 1'b0;
                end
            end
            StFlush: begin
                if (accept) begin
                    wren_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = busy_q;
        if ((state_q == StIdle) && pop) begin
            busy_d = 1'b1;
        end else if (done_q | err_q) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            words_left_q <= '0;
            len_lsb_q    <= '0;
            next_addr_q  <= '0;
            wren_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            words_left_q <= words_left_d;
            len_lsb_q    <= len_lsb_d;
            next_addr_q  <= next_addr_d;
            wren_q       <= wren_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    // Pop is masked during reset so a non-empty FIFO is not drained while held.
    assign fifo_rd_en = pop & rst_n;
    assign mem_wren   = wren_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_wstrb  = wstrb_q;
    assign busy       = busy_q;
    assign done_pulse = done_q;
    assign err_pulse  = err_q;
    assign pkt_cnt    = cnt_q;

    assert property (@(posedge clk) disable iff (!rst_n) fifo_rd_en |-> !fifo_empty);
    assert property (@(posedge clk) disable iff (!rst_n) (mem_wren && !mem_ready) |-> !fifo_rd_en);
    assert property (@(posedge clk) disable iff (!rst_n) mem_addr[1:0] == 2'b00);

endmodule

// File: tb/tb_dma_fifo_drain.sv
// Directed bench for dma_fifo_drain: background FIFO/memory models plus one task per
// scenario, each checking writes, pulses and cycle timing against hand-derived values.
`timescale 1ns/1ps
module tb_dma_fifo_drain;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             fifo_empty;
    logic [31:0]      fifo_dout;
    logic             fifo_rd_en;
    logic             mem_wren;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_wstrb;
    logic             mem_ready;
    logic             busy;
    logic             done_pulse;
    logic             err_pulse;
    logic [CNT_W-1:0] pkt_cnt;

    dma_fifo_drain #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .mem_wren   (mem_wren),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .busy       (busy),
        .done_pulse (done_pulse),
        .err_pulse  (err_pulse),
        .pkt_cnt    (pkt_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [CNT_W-1:0] exp_pkt = '0;

    // Background model state
    logic [31:0] q[$];
    int          cyc = 0;
    int          pop_cyc[$];
    int          acc_cyc[$];
    logic [31:0] acc_addr[$];
    logic [31:0] acc_data[$];
    logic [3:0]  acc_strb[$];
    int          done_cyc[$];
    int          err_cyc[$];
    logic        busy_log[$];
    int          viol = 0;
    int          ready_mode = 0;
    int          gap_at = -1;
    int          gap_len = 0;
    int          gap_rem = 0;
    int          pop_total = 0;
    logic        stalled = 1'b0;
    logic [31:0] hold_addr, hold_data;
    logic [3:0]  hold_strb;

    // Inputs change at negedge; everything is sampled 1ns before the next posedge.
    initial begin
        fifo_empty = 1'b1;
        fifo_dout  = '0;
        mem_ready  = 1'b1;
        forever begin
            @(negedge clk);
            if (ready_mode == 0) mem_ready = 1'b1;
            else if (ready_mode == 1) mem_ready = ~mem_ready;
            else mem_ready = 1'b0;
            if (gap_rem > 0) begin
                fifo_empty = 1'b1;
                gap_rem--;
            end else begin
                fifo_empty = (q.size() == 0);
            end
            fifo_dout = (q.size() != 0) ? q[0] : 32'h0;
            #4;
            busy_log.push_back(busy);
            if (rst_n) begin
                if (stalled && (!mem_wren || mem_addr !== hold_addr || mem_wdata !== hold_data ||
                                mem_wstrb !== hold_strb)) viol++;
                if (fifo_rd_en && fifo_empty) viol++;
                if (mem_wren && !mem_ready && fifo_rd_en) viol++;
                if (done_pulse) done_cyc.push_back(cyc);
                if (err_pulse) err_cyc.push_back(cyc);
                if (mem_wren && mem_ready) begin
                    acc_cyc.push_back(cyc);
                    acc_addr.push_back(mem_addr);
                    acc_data.push_back(mem_wdata);
                    acc_strb.push_back(mem_wstrb);
                end
                stalled   = mem_wren && !mem_ready;
                hold_addr = mem_addr;
                hold_data = mem_wdata;
                hold_strb = mem_wstrb;
                if (fifo_rd_en && q.size() != 0) begin
                    pop_cyc.push_back(cyc);
                    void'(q.pop_front());
                    pop_total++;
                    if (pop_total == gap_at) gap_rem = gap_len;
                end
            end else begin
                stalled = 1'b0;
            end
            cyc++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    // Called at a posedge, when the background process is idle.
    task automatic clear_logs();
        cyc = 0;
        pop_cyc.delete();
        acc_cyc.delete();
        acc_addr.delete();
        acc_data.delete();
        acc_strb.delete();
        done_cyc.delete();
        err_cyc.delete();
        busy_log.delete();
        viol      = 0;
        pop_total = 0;
        gap_at    = -1;
        gap_len   = 0;
        gap_rem   = 0;
        stalled   = 1'b0;
    endtask

    task automatic push_pkt(input logic [15:0] len, input logic [31:0] addr, input int nwords,
                            input logic [31:0] seed);
        q.push_back({len, 16'h5A5A});
        q.push_back(addr);
        for (int i = 0; i < nwords; i++) q.push_back(seed + 32'(i));
    endtask

    task automatic wait_idle(input int want_done, input int want_err, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            if (done_cyc.size() >= want_done && err_cyc.size() >= want_err && q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if ({fifo_rd_en, mem_wren, busy, done_pulse, err_pulse} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: rd/wren/busy/done/err=%b want 00000",
                     {fifo_rd_en, mem_wren, busy, done_pulse, err_pulse});
        end
        checks++;
        if (mem_addr !== 32'h0) begin
            errors++; $display("FAIL reset_addr: got %h want 0", mem_addr);
        end
        checks++;
        if (mem_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_wdata: got %h want 0", mem_wdata);
        end
        checks++;
        if (mem_wstrb !== 4'h0) begin
            errors++; $display("FAIL reset_wstrb: got %h want 0", mem_wstrb);
        end
        checks++;
        if (pkt_cnt !== '0) begin
            errors++; $display("FAIL reset_pkt_cnt: got %0d want 0", pkt_cnt);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        bit ok;
        logic [67:0] got, exp;
        @(posedge clk);
        clear_logs();
        push_pkt(16'd8, 32'h0000_1000, 2, 32'hA000_0000);
        wait_idle(1, 0, ok);
        exp_pkt = exp_pkt + 1'b1;
        checks++;
        if (!ok || acc_cyc.size() != 2 || done_cyc.size() != 1) begin
            errors++;
            $display("FAIL basic_count: ok=%0d writes=%0d dones=%0d want 1/2/1", ok,
                     acc_cyc.size(), done_cyc.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                got = {acc_addr[i], acc_data[i], acc_strb[i]};
                exp = {32'h1000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF};
                checks++;
                if (got !== exp) begin
                    errors++; $display("FAIL basic_w%0d: got %h want %h", i, got, exp);
                end
            end
            checks++;
            if (acc_cyc[0] - pop_cyc[0] != 3 || acc_cyc[1] - pop_cyc[0] != 4 ||
                done_cyc[0] - pop_cyc[0] != 5) begin
                errors++;
                $display("FAIL basic_timing: acc %0d,%0d done %0d want 3,4 done 5",
                         acc_cyc[0] - pop_cyc[0], acc_cyc[1] - pop_cyc[0],
                         done_cyc[0] - pop_cyc[0]);
            end
            checks++;
            if ({busy_log[pop_cyc[0]], busy_log[pop_cyc[0] + 1], busy_log[done_cyc[0]],
                 busy_log[done_cyc[0] + 1]} !== 4'b0110) begin
                errors++;
                $display("FAIL basic_busy: got %b want 0110", {busy_log[pop_cyc[0]],
                         busy_log[pop_cyc[0] + 1], busy_log[done_cyc[0]],
                         busy_log[done_cyc[0] + 1]});
            end
        end
        checks++;
        if (pkt_cnt !== exp_pkt) begin
            errors++; $display("FAIL basic_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt);
        end
        checks++;
        if (viol != 0) begin
            errors++; $display("FAIL basic_protocol: violations %0d want 0", viol);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [67:0] got, exp;
        @(posedge clk);
        clear_logs();
        push_pkt(16'd4, 32'h0000_1100, 1, 32'h1111_0000);
        push_pkt(16'd4, 32'h0000_1200, 1, 32'h2222_0000);
        wait_idle(2, 0, ok);
        exp_pkt = exp_pkt + 2'd2;
        checks++;
        if (!ok || acc_cyc.size() != 2 || done_cyc.size() != 2 || pop_cyc.size() != 6) begin
            errors++;
            $display("FAIL b2b_count: ok=%0d writes=%0d dones=%0d pops=%0d want 1/2/2/6", ok,
                     acc_cyc.size(), done_cyc.size(), pop_cyc.size());
        end else begin
            checks++;
            if (done_cyc[0] - pop_cyc[0] != 4 || pop_cyc[3] - done_cyc[0] != 1) begin
                errors++;
                $display("FAIL b2b_timing: done %0d next pop +%0d want 4 and +1",
                         done_cyc[0] - pop_cyc[0], pop_cyc[3] - done_cyc[0]);
            end
            got = {acc_addr[1], acc_data[1], acc_strb[1]};
            exp = {32'h0000_1200, 32'h2222_0000, 4'hF};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL b2b_w1: got %h want %h", got, exp);
            end
        end
        checks++;
        if (pkt_cnt !== exp_pkt) begin
            errors++; $display("FAIL b2b_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt);
        end
    endtask

    task automatic test_tail_strobe();
        bit ok;
        logic [67:0] got, exp;
        logic [3:0] want_strb;
        for (int t = 0; t < 3; t++) begin
            if (t == 0) want_strb = 4'h1;
            else if (t == 1) want_strb = 4'h3;
            else want_strb = 4'h7;
            @(posedge clk);
            clear_logs();
            push_pkt(16'(5 + t), 32'h2003 + 32'(t) * 32'h0FFF, 2, 32'hB000_0000 + 32'(t * 16));
            wait_idle(1, 0, ok);
            exp_pkt = exp_pkt + 1'b1;
            checks++;
            if (!ok || acc_cyc.size() != 2) begin
                errors++;
                $display("FAIL tail%0d_count: ok=%0d writes=%0d want 1/2", t, ok, acc_cyc.size());
            end else begin
                for (int i = 0; i < 2; i++) begin
                    got = {acc_addr[i], acc_data[i], acc_strb[i]};
                    exp = {32'h2000 + 32'(t) * 32'h1000 + 32'(4 * i),
                           32'hB000_0000 + 32'(t * 16) + 32'(i), (i == 1) ? want_strb : 4'hF};
                    checks++;
                    if (got !== exp) begin
                        errors++; $display("FAIL tail%0d_w%0d: got %h want %h", t, i, got, exp);
                    end
                end
            end
        end
    endtask

    task automatic test_addr_wrap();
        bit ok;
        @(posedge clk);
        clear_logs();
        push_pkt(16'd8, 32'hFFFF_FFFE, 2, 32'hE000_0000);
        wait_idle(1, 0, ok);
        exp_pkt = exp_pkt + 1'b1;
        checks++;
        if (!ok || acc_cyc.size() != 2) begin
            errors++; $display("FAIL wrap_count: ok=%0d writes=%0d want 1/2", ok, acc_cyc.size());
        end else begin
            checks++;
            if ({acc_addr[0], acc_addr[1]} !== {32'hFFFF_FFFC, 32'h0000_0000}) begin
                errors++;
                $display("FAIL wrap_addr: got %h %h want fffffffc 00000000", acc_addr[0],
                         acc_addr[1]);
            end
        end
    endtask

    task automatic test_ready_toggle();
        bit ok;
        logic [67:0] got, exp;
        @(posedge clk);
        clear_logs();
        ready_mode = 1;
        push_pkt(16'd12, 32'h0000_5000, 3, 32'hD000_0000);
        wait_idle(1, 0, ok);
        ready_mode = 0;
        exp_pkt = exp_pkt + 1'b1;
        checks++;
        if (!ok || acc_cyc.size() != 3 || pop_cyc.size() != 5) begin
            errors++;
            $display("FAIL toggle_count: ok=%0d writes=%0d pops=%0d want 1/3/5", ok,
                     acc_cyc.size(), pop_cyc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                got = {acc_addr[i], acc_data[i], acc_strb[i]};
                exp = {32'h5000 + 32'(4 * i), 32'hD000_0000 + 32'(i), 4'hF};
                checks++;
                if (got !== exp) begin
                    errors++; $display("FAIL toggle_w%0d: got %h want %h", i, got, exp);
                end
            end
        end
        checks++;
        if (viol != 0) begin
            errors++; $display("FAIL toggle_stall: violations %0d want 0", viol);
        end
        checks++;
        if (pkt_cnt !== exp_pkt) begin
            errors++; $display("FAIL toggle_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt);
        end
    endtask

    task automatic test_zero_len();
        bit ok;
        logic [67:0] got, exp;
        @(posedge clk);
        clear_logs();
        push_pkt(16'd0, 32'h0000_6000, 0, 32'h0);
        push_pkt(16'd4, 32'h0000_6100, 1, 32'h7777_0000);
        wait_idle(1, 1, ok);
        exp_pkt = exp_pkt + 1'b1;
        checks++;
        if (!ok || err_cyc.size() != 1 || done_cyc.size() != 1 || acc_cyc.size() != 1) begin
            errors++;
            $display("FAIL zero_count: ok=%0d errs=%0d dones=%0d writes=%0d want 1/1/1/1", ok,
                     err_cyc.size(), done_cyc.size(), acc_cyc.size());
        end else begin
            checks++;
            if (err_cyc[0] - pop_cyc[0] != 2 || pop_cyc[2] - pop_cyc[0] != 3) begin
                errors++;
                $display("FAIL zero_timing: err %0d next pop %0d want 2 and 3",
                         err_cyc[0] - pop_cyc[0], pop_cyc[2] - pop_cyc[0]);
            end
            got = {acc_addr[0], acc_data[0], acc_strb[0]};
            exp = {32'h0000_6100, 32'h7777_0000, 4'hF};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL zero_w0: got %h want %h", got, exp);
            end
        end
        checks++;
        if (pkt_cnt !== exp_pkt) begin
            errors++; $display("FAIL zero_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt);
        end
    endtask

    task automatic test_fifo_gap();
        bit ok;
        logic [67:0] got, exp;
        @(posedge clk);
        clear_logs();
        gap_at  = 4;
        gap_len = 5;
        push_pkt(16'd16, 32'h0000_7000, 4, 32'hF000_0000);
        wait_idle(1, 0, ok);
        exp_pkt = exp_pkt + 1'b1;
        checks++;
        if (!ok || acc_cyc.size() != 4 || err_cyc.size() != 0) begin
            errors++;
            $display("FAIL gap_count: ok=%0d writes=%0d errs=%0d want 1/4/0", ok,
                     acc_cyc.size(), err_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                got = {acc_addr[i], acc_data[i], acc_strb[i]};
                exp = {32'h7000 + 32'(4 * i), 32'hF000_0000 + 32'(i), 4'hF};
                checks++;
                if (got !== exp) begin
                    errors++; $display("FAIL gap_w%0d: got %h want %h", i, got, exp);
                end
            end
            checks++;
            if (acc_cyc[1] - pop_cyc[0] != 4 || acc_cyc[2] - pop_cyc[0] != 10 ||
                done_cyc[0] - pop_cyc[0] != 12) begin
                errors++;
                $display("FAIL gap_timing: acc1 %0d acc2 %0d done %0d want 4 10 12",
                         acc_cyc[1] - pop_cyc[0], acc_cyc[2] - pop_cyc[0],
                         done_cyc[0] - pop_cyc[0]);
            end
        end
    endtask

    task automatic test_reset_midpacket();
        bit ok;
        logic [67:0] got, exp;
        @(posedge clk);
        clear_logs();
        push_pkt(16'd16, 32'h0000_8000, 4, 32'h8800_0000);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (acc_cyc.size() >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++; $display("FAIL rstmid_wait: writes=%0d want 2", acc_cyc.size());
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fifo_rd_en, mem_wren, busy, done_pulse, err_pulse} !== 5'b0) begin
            errors++;
            $display("FAIL rstmid_ctrl: rd/wren/busy/done/err=%b want 00000",
                     {fifo_rd_en, mem_wren, busy, done_pulse, err_pulse});
        end
        checks++;
        if ({mem_addr, mem_wdata, mem_wstrb} !== 68'h0) begin
            errors++;
            $display("FAIL rstmid_data: addr %h wdata %h wstrb %h want 0", mem_addr, mem_wdata,
                     mem_wstrb);
        end
        checks++;
        if (pkt_cnt !== '0) begin
            errors++; $display("FAIL rstmid_pkt_cnt: got %0d want 0", pkt_cnt);
        end
        exp_pkt = '0;
        @(posedge clk);
        q.delete();
        clear_logs();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        push_pkt(16'd8, 32'h0000_9000, 2, 32'hC000_0000);
        wait_idle(1, 0, ok);
        exp_pkt = exp_pkt + 1'b1;
        checks++;
        if (!ok || acc_cyc.size() != 2 || err_cyc.size() != 0) begin
            errors++;
            $display("FAIL rstmid_after_count: ok=%0d writes=%0d errs=%0d want 1/2/0", ok,
                     acc_cyc.size(), err_cyc.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                got = {acc_addr[i], acc_data[i], acc_strb[i]};
                exp = {32'h9000 + 32'(4 * i), 32'hC000_0000 + 32'(i), 4'hF};
                checks++;
                if (got !== exp) begin
                    errors++; $display("FAIL rstmid_after_w%0d: got %h want %h", i, got, exp);
                end
            end
        end
        checks++;
        if (pkt_cnt !== exp_pkt) begin
            errors++; $display("FAIL rstmid_after_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_tail_strobe();
        test_addr_wrap();
        test_ready_toggle();
        test_zero_len();
        test_fifo_gap();
        test_reset_midpacket();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
